// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter and sequencer that shares one registered
// ula between two requesters. A granted request is latched, issued to the
// ula, held stable for the ula latency, and its result is returned with a
// one-cycle res_valid pulse tagged with the owner id. Opcodes 100/101 have
// no ula implementation and are rejected without being issued.
module ula_arbitro #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [2:0]   op0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [2:0]   op1,
  output logic         gnt1,
  output logic [N-1:0] ula_a,
  output logic [N-1:0] ula_b,
  output logic [2:0]   ula_op,
  input  logic [N-1:0] ula_s,
  input  logic         ula_flag,
  output logic [N-1:0] res,
  output logic         res_flag,
  output logic         res_id,
  output logic         res_err,
  output logic         res_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic            rr_r;      // 1 = requester 1 favoured on a tie
  logic            owner_r;
  logic            gnt0_s;
  logic            gnt1_s;
  logic [N-1:0]    sel_a_s;
  logic [N-1:0]    sel_b_s;
  logic [2:0]      sel_op_s;

  // Opcodes 100 and 101 have no ula implementation.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      3'b100:  ok = 1'b0;
      3'b101:  ok = 1'b0;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign gnt0 = gnt0_s;
  assign gnt1 = gnt1_s;

  // Grant selection, operand mux and next-state decode.
  always_comb begin
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
    state_s  = state_r;
    sel_a_s  = a0;
    sel_b_s  = b0;
    sel_op_s = op0;
    case (state_r)
      IDLE: begin
        // Grants are combinational, so suppress them while reset is held.
        if (rst) begin
          state_s = IDLE;
        end else if (req0 && (!req1 || !rr_r)) begin
          gnt0_s = 1'b1;
        end else if (req1) begin
          gnt1_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
        if (gnt1_s) begin
          sel_a_s  = a1;
          sel_b_s  = b1;
          sel_op_s = op1;
        end else begin
          sel_a_s  = a0;
          sel_b_s  = b0;
          sel_op_s = op0;
        end
        if (gnt0_s || gnt1_s) begin
          state_s = op_legal(sel_op_s) ? ISSUE : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (cnt_r == CW'(0)) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, latency counter, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      rr_r      <= 1'b0;
      owner_r   <= 1'b0;
      ula_a     <= {N{1'b0}};
      ula_b     <= {N{1'b0}};
      ula_op    <= 3'b000;
      res       <= {N{1'b0}};
      res_flag  <= 1'b0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy      <= (state_s != IDLE);
      res_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (gnt0_s || gnt1_s) begin
            rr_r    <= gnt0_s;
            owner_r <= gnt1_s;
            if (op_legal(sel_op_s)) begin
              // Operands stay on the ula ports until the next legal grant.
              ula_a  <= sel_a_s;
              ula_b  <= sel_b_s;
              ula_op <= sel_op_s;
            end else begin
              // Rejected op completes immediately without touching the ula.
              res      <= {N{1'b0}};
              res_flag <= 1'b0;
              res_err  <= 1'b1;
              res_id   <= gnt1_s;
            end
          end else begin
            rr_r <= rr_r;
          end
        end
        ISSUE: cnt_r <= CW'(LAT - 1);
        WAIT: begin
          if (cnt_r == CW'(0)) begin
            res      <= ula_s;
            res_flag <= ula_flag;
            res_err  <= 1'b0;
            res_id   <= owner_r;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE:    cnt_r <= cnt_r;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with a small behavioural two-stage ula.
module tb_ula_arbitro;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       gnt0, gnt1;
  logic [7:0] ula_a, ula_b, ula_s;
  logic [2:0] ula_op;
  logic       ula_flag;
  logic [7:0] res;
  logic       res_flag, res_id, res_err, res_valid, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ula_arbitro #(.N(8), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_flag(ula_flag),
    .res(res), .res_flag(res_flag), .res_id(res_id), .res_err(res_err),
    .res_valid(res_valid), .busy(busy)
  );

  // ula model: input register stage then output register stage.
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;

  function automatic logic [8:0] ula_calc(input logic [7:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a ^ b};
      3'b011:  return {1'b0, ~a};
      3'b110:  return {8'd0, (a == b)};
      3'b111:  return {1'b0, b};
      default: return 9'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= 8'd0; m_b <= 8'd0; m_op <= 3'd0;
      ula_s <= 8'd0; ula_flag <= 1'b0;
    end else begin
      m_a <= ula_a; m_b <= ula_b; m_op <= ula_op;
      {ula_flag, ula_s} <= ula_calc(m_a, m_b, m_op);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant in the current (IDLE) cycle, then follow the op to completion.
  task automatic run_op(input string tag, input bit id, input logic [7:0] a, b,
                        input logic [2:0] op, input logic [7:0] er,
                        input logic ef, ee, input int el);
    int lat;
    lat = 0;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    #1;
    chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'hA5; b0 = 8'h5A; a1 = 8'h3C; b1 = 8'hC3;
        op0 = 3'b111; op1 = 3'b111;
      end
      #1;
      chk({tag, "_nognt"}, {30'd0, gnt1, gnt0}, 32'd0);
      chk({tag, "_op_issued"}, {31'd0, (ula_op == 3'b100) || (ula_op == 3'b101)}, 32'd0);
      if (c < el) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (res_valid) begin lat = c; break; end
    end
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_res"}, {24'd0, res}, {24'd0, er});
    chk({tag, "_flag"}, {31'd0, res_flag}, {31'd0, ef});
    chk({tag, "_id"}, {31'd0, res_id}, {31'd0, id});
    chk({tag, "_err"}, {31'd0, res_err}, {31'd0, ee});
    @(posedge clk); #2;
    chk({tag, "_pulse"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_hold"}, {24'd0, res}, {24'd0, er});
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0; op0 = 3'd0; op1 = 3'd0;
    #12;
    chk("rst_outs", {ula_a, ula_b, ula_op, res, res_flag, res_id, res_err, res_valid, busy},
        32'd0);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 200+100 wraps to 44 with carry.
    run_op("add0", 1'b0, 8'd200, 8'd100, 3'b000, 8'd44, 1'b1, 1'b0, 4);
    run_op("xor1", 1'b1, 8'hF0, 8'h3C, 3'b010, 8'hCC, 1'b0, 1'b0, 4);
    run_op("eq1", 1'b1, 8'd7, 8'd7, 3'b110, 8'd1, 1'b0, 1'b0, 4);

    // Both requesting continuously: grants alternate every 5 cycles.
    req0 = 1'b1; a0 = 8'd1; b0 = 8'd1; op0 = 3'b000;
    req1 = 1'b1; a1 = 8'h0F; b1 = 8'h00; op1 = 3'b011;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      else #1;
      chk("rr_gnt0", {31'd0, gnt0}, {31'd0, (c % 5 == 0) && ((c / 5) % 2 == 0)});
      chk("rr_gnt1", {31'd0, gnt1}, {31'd0, (c % 5 == 0) && ((c / 5) % 2 == 1)});
      chk("rr_valid", {31'd0, res_valid}, {31'd0, (c % 5 == 4)});
      if (c % 5 == 4) begin
        chk("rr_id", {31'd0, res_id}, {31'd0, ((c / 5) % 2 == 1)});
        chk("rr_res", {24'd0, res}, ((c / 5) % 2 == 1) ? 32'hF0 : 32'h02);
        chk("rr_flag", {31'd0, res_flag}, 32'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Unimplemented opcode: rejected, answered in the next cycle.
    run_op("rej0", 1'b0, 8'd9, 8'd9, 3'b100, 8'd0, 1'b0, 1'b1, 1);

    // Reset during WAIT aborts the op; the held request is served afterwards.
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd4; op0 = 3'b000;
    #1;
    chk("ab_gnt", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ab_outs", {ula_a, ula_b, ula_op, res, res_flag, res_id, res_err, res_valid, busy},
        32'd0);
    chk("ab_gnt_rst", {30'd0, gnt1, gnt0}, 32'd0);
    @(posedge clk); #1;
    chk("ab_novalid", {31'd0, res_valid}, 32'd0);
    rst = 1'b0;
    run_op("ab_redo", 1'b0, 8'd3, 8'd4, 3'b000, 8'd7, 1'b0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
